// File: rtl/fwd_scoreboard_if.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_if
//   Decode-side bundle between the decode stage and the forwarding scoreboard.
//
//   Issue side (driven by decode / master):
//     issue_valid, issue_wr, issue_load, issue_rd  - instruction being decoded
//     src_tag, src_use                             - packed source tags + usage
//     flush                                        - squash decode this cycle
//   Result side (driven by scoreboard / slave):
//     fwd_sel    - per-port bypass select, 0 = regfile, k+1 = stage k result
//     stall      - hold decode/fetch and insert a bubble
//     pipe_busy  - at least one producer is in flight
// -----------------------------------------------------------------------------
interface fwd_scoreboard_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = 2
);
  logic                       issue_valid;
  logic                       issue_wr;
  logic                       issue_load;
  logic [REG_W-1:0]           issue_rd;
  logic [NUM_SRC*REG_W-1:0]   src_tag;
  logic [NUM_SRC-1:0]         src_use;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;
  logic                       pipe_busy;

  modport master (
    output issue_valid, issue_wr, issue_load, issue_rd, src_tag, src_use, flush,
    input  fwd_sel, stall, pipe_busy
  );

  modport slave (
    input  issue_valid, issue_wr, issue_load, issue_rd, src_tag, src_use, flush,
    output fwd_sel, stall, pipe_busy
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
//   Forwarding and load-use hazard unit sitting beside decode. Keeps a shift
//   register of in-flight producers (entry 0 = EX, 1 = MEM, ...) and, for every
//   source port, picks the youngest matching producer as the bypass source or
//   requests a stall when that producer is a load whose data is not ready yet.
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-high; drops every tracked entry
//     sb     - fwd_scoreboard_if.slave (issue inputs, fwd_sel/stall/pipe_busy)
//   Optional (macro FWD_SCOREBOARD_STATS_EN):
//     fwd_count   - saturating count of issued cycles using any bypass
//     stall_count - saturating count of stalled cycles
//
//   Parameters: REG_W (tag width), NUM_SRC (source ports), DEPTH (tracked
//   stages), LOAD_LAT (first stage where load data can be bypassed,
//   1..DEPTH-1). The interface must be built with SEL_W = $clog2(DEPTH+1).
//   Outputs are purely combinational from state and the current inputs.
// -----------------------------------------------------------------------------
module fwd_scoreboard #(
  parameter int REG_W    = 5,
  parameter int NUM_SRC  = 3,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef FWD_SCOREBOARD_STATS_EN
  fwd_scoreboard_if.slave      sb,
  output logic [31:0]          fwd_count,
  output logic [31:0]          stall_count
`else
  fwd_scoreboard_if.slave      sb
`endif
);

  localparam int SEL_W = $clog2(DEPTH + 1);
  // X31/XZR: never a real producer, never a real dependency.
  localparam logic [REG_W-1:0] ZERO_REG = '1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } entry_t;

  entry_t pipe_q [DEPTH];
  entry_t new_entry;

  logic [SEL_W-1:0] port_sel [NUM_SRC];
  logic [NUM_SRC-1:0] port_haz;
  logic stall_int;

  // ---------------------------------------------------------------------------
  // Per-port match. Scanning from the youngest entry and stopping at the first
  // hit means an older load is automatically masked by a younger writer of the
  // same register.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [REG_W-1:0] tag;
    logic             found;
    // NOTE: every comb output gets a default before any conditional write, so
    // no path leaves a value held and no latch is inferred.
    port_haz = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      port_sel[i] = '0;
      tag   = sb.src_tag[i*REG_W +: REG_W];
      found = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && pipe_q[k].valid && (pipe_q[k].rd == tag) &&
            (tag != ZERO_REG) && sb.src_use[i]) begin
          // NOTE: blocking '=' inside always_comb so later iterations see the
          // updated 'found' within the same evaluation.
          found = 1'b1;
          if (pipe_q[k].is_load && (k < LOAD_LAT)) begin
            port_haz[i] = 1'b1;   // data not ready: select stays regfile (0)
          end else begin
            port_sel[i] = SEL_W'(k + 1);
          end
        end
      end
    end
  end

  // Output packing and stall/busy generation.
  always_comb begin
    sb.fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sb.fwd_sel[i*SEL_W +: SEL_W] = port_sel[i];
    end
  end

  // Flush wins over a hazard: the squashed instruction needs no operands.
  assign stall_int = sb.issue_valid && !sb.flush && (|port_haz);
  assign sb.stall  = stall_int;

  always_comb begin
    sb.pipe_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      sb.pipe_busy = sb.pipe_busy | pipe_q[k].valid;
    end
  end

  // Entry inserted at EX: a bubble unless a real register write leaves decode.
  always_comb begin
    new_entry         = '0;
    new_entry.rd      = sb.issue_rd;
    new_entry.is_load = sb.issue_load;
    new_entry.valid   = sb.issue_valid && sb.issue_wr && (sb.issue_rd != ZERO_REG) &&
                        !stall_int && !sb.flush;
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline. Older entries always advance, even while decode is stalled;
  // the last entry retires into the write-before-read register file.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: only 'valid' matters after reset, but the array is tiny, so the
      // whole entry is cleared to keep rd/is_load free of X in simulation.
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking '<=' for state so every entry shifts from its
      // pre-edge value regardless of statement order.
      pipe_q[0] <= new_entry;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  // Saturating event counters.
  logic fwd_event;
  assign fwd_event = sb.issue_valid && !stall_int && !sb.flush && (|sb.fwd_sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_count   <= '0;
      stall_count <= '0;
    end else begin
      if (fwd_event && (fwd_count != 32'hFFFF_FFFF)) begin
        fwd_count <= fwd_count + 32'd1;
      end
      if (stall_int && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_scoreboard
//   Directed bench for fwd_scoreboard (NUM_SRC=3, DEPTH=2, LOAD_LAT=1).
//   Each step drives decode inputs after the falling edge, pushes the expected
//   {fwd_sel, stall, pipe_busy} into a queue, and pops/compares it 1 time unit
//   later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_fwd_scoreboard;

  localparam int REG_W    = 5;
  localparam int NUM_SRC  = 3;
  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;
  localparam int SEL_W    = $clog2(DEPTH + 1);

  typedef struct {
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     stall;
    logic                     busy;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t exp_q [$];

  fwd_scoreboard_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] fwd_count;
  logic [31:0] stall_count;
`endif

  fwd_scoreboard #(
    .REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef FWD_SCOREBOARD_STATS_EN
    .sb         (bus.slave),
    .fwd_count  (fwd_count),
    .stall_count(stall_count)
`else
    .sb         (bus.slave)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NUM_SRC*REG_W-1:0] tags(input logic [4:0] t2,
                                                     input logic [4:0] t1,
                                                     input logic [4:0] t0);
    return {t2, t1, t0};
  endfunction

  task automatic expect_push(input logic [5:0] sel, input logic stl, input logic busy);
    exp_t e;
    e.sel = sel; e.stall = stl; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic compare(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    tests++;
    assert (bus.fwd_sel === e.sel) else begin
      fails++;
      $error("FAIL %s fwd_sel observed=%0h expected=%0h", name, bus.fwd_sel, e.sel);
    end
    tests++;
    assert (bus.stall === e.stall) else begin
      fails++;
      $error("FAIL %s stall observed=%0b expected=%0b", name, bus.stall, e.stall);
    end
    tests++;
    assert (bus.pipe_busy === e.busy) else begin
      fails++;
      $error("FAIL %s pipe_busy observed=%0b expected=%0b", name, bus.pipe_busy, e.busy);
    end
  endtask

  // One decode cycle: drive, record expectation, compare before the edge.
  task automatic step(input string name,
                      input logic v, input logic wr, input logic ld, input logic [4:0] rd,
                      input logic [NUM_SRC*REG_W-1:0] st, input logic [2:0] su,
                      input logic fl,
                      input logic [5:0] e_sel, input logic e_stall, input logic e_busy);
    @(negedge clk);
    bus.issue_valid = v;
    bus.issue_wr    = wr;
    bus.issue_load  = ld;
    bus.issue_rd    = rd;
    bus.src_tag     = st;
    bus.src_use     = su;
    bus.flush       = fl;
    expect_push(e_sel, e_stall, e_busy);
    #1;
    compare(name);
  endtask

`ifdef FWD_SCOREBOARD_STATS_EN
  task automatic stats_check(input string name, input logic [31:0] e_fwd,
                             input logic [31:0] e_stall);
    tests++;
    assert (fwd_count === e_fwd) else begin
      fails++;
      $error("FAIL %s fwd_count observed=%0d expected=%0d", name, fwd_count, e_fwd);
    end
    tests++;
    assert (stall_count === e_stall) else begin
      fails++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", name, stall_count, e_stall);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_wr    = 1'b0;
    bus.issue_load  = 1'b0;
    bus.issue_rd    = '0;
    bus.src_tag     = '0;
    bus.src_use     = '0;
    bus.flush       = 1'b0;

    // Reset state.
    #2;
    expect_push(6'd0, 1'b0, 1'b0);
    compare("reset");
`ifdef FWD_SCOREBOARD_STATS_EN
    stats_check("reset_stats", 32'd0, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // ALU back-to-back: ADD X3, reader at EX then at MEM.
    step("add_x3",      1,1,0,5'd3,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 0);
    step("rd_x3_ex",    1,0,0,5'd0,  tags(0,0,3),  3'b001, 0, 6'd1,  0, 1);
    step("rd_x3_mem",   1,0,0,5'd0,  tags(0,0,3),  3'b001, 0, 6'd2,  0, 1);

    // Load-use: LDUR X5, reader on port 1 stalls once, then bypasses from MEM.
    step("ldur_x5",     1,1,1,5'd5,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 0);
    step("lu_stall",    1,0,0,5'd0,  tags(0,5,0),  3'b010, 0, 6'd0,  1, 1);
    step("lu_release",  1,0,0,5'd0,  tags(0,5,0),  3'b010, 0, 6'd8,  0, 1);
    step("lu_drained",  0,0,0,5'd0,  tags(0,0,5),  3'b001, 0, 6'd0,  0, 0);

    // Priority: ADD X7, SUB X7, reader on ports 0 and 2 (port 1 tagged, unused).
    step("add_x7",      1,1,0,5'd7,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 0);
    step("sub_x7",      1,1,0,5'd7,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 1);
    step("rd_x7_prio",  1,0,0,5'd0,  tags(7,7,7),  3'b101, 0, 6'd17, 0, 1);
    step("idle_a",      0,0,0,5'd0,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 1);

    // Older load masked by younger ALU writer of the same register.
    step("ldur_x9",     1,1,1,5'd9,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 0);
    step("add_x9",      1,1,0,5'd9,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 1);
    step("rd_x9_mask",  1,0,0,5'd0,  tags(0,0,9),  3'b001, 0, 6'd1,  0, 1);

    // XZR: never tracked, never matched.
    step("add_xzr",     1,1,0,5'd31, tags(0,0,0),  3'b000, 0, 6'd0,  0, 1);
    step("rd_xzr",      1,0,0,5'd0,  tags(0,31,31),3'b011, 0, 6'd0,  0, 0);

    // Flush with a load-use hazard: no stall and nothing inserted.
    step("ldur_x4",     1,1,1,5'd4,  tags(0,0,0),  3'b000, 0, 6'd0,  0, 0);
    step("flush_haz",   1,1,0,5'd8,  tags(4,0,0),  3'b100, 1, 6'd0,  0, 1);
    step("post_flush",  0,0,0,5'd0,  tags(4,0,8),  3'b101, 0, 6'd32, 0, 1);

    // Two valid entries, then asynchronous reset between clock edges.
    step("add_x10",     1,1,0,5'd10, tags(0,0,0),  3'b000, 0, 6'd0,  0, 0);
`ifdef FWD_SCOREBOARD_STATS_EN
    stats_check("stats_run", 32'd5, 32'd1);
`endif
    step("add_x11",     1,1,0,5'd11, tags(0,0,0),  3'b000, 0, 6'd0,  0, 1);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.issue_wr    = 1'b0;
    bus.src_tag     = tags(0,0,11);
    bus.src_use     = 3'b001;
    expect_push(6'd1, 1'b0, 1'b1);
    #1;
    compare("pre_async_rst");
    reset = 1'b1;
    #1;
    expect_push(6'd0, 1'b0, 1'b0);
    compare("async_rst");
`ifdef FWD_SCOREBOARD_STATS_EN
    stats_check("stats_rst", 32'd0, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    step("after_rst",   0,0,0,5'd0,  tags(0,0,10), 3'b001, 0, 6'd0,  0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined ARM core.
- Tracks in-flight producers in an internal tag pipeline of DEPTH stages: stage 0 = EX, stage 1 = MEM, and so on.
- Per source operand, it produces a bypass-mux select and a decode-stage stall request.
- Sits beside the decode stage. It replaces per-stage rd comparisons with a scoreboard generalised in read-port count, pipeline depth and load latency.

Parameters:
- REG_W, 5, register tag width. Tag all-ones (X31/XZR) never forwards or stalls.
- NUM_SRC, 3, number of source operand ports (rm, rn, rd-as-source).
- DEPTH, 2, producer stages tracked after decode. SEL_W = $clog2(DEPTH+1).
- LOAD_LAT, 1, first stage index at which load data is forwardable. Range 1..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode holds a real instruction.
- issue_wr  in  1  issuing instruction writes a register.
- issue_load  in  1  issuing instruction is a load.
- issue_rd  in  REG_W  issuing instruction's destination tag.
- src_tag  in  NUM_SRC*REG_W  source tags; port i at bits [i*REG_W +: REG_W].
- src_use  in  NUM_SRC  port i is actually read by the decoding instruction.
- flush  in  1  squash the instruction currently in decode.
- fwd_sel  out  NUM_SRC*SEL_W  per port: 0 = register file, k+1 = result of stage k.
- stall  out  1  hold decode/fetch this cycle and insert a bubble.
- pipe_busy  out  1  at least one valid entry is tracked.

Behaviour:
- State: DEPTH entries, each holding {valid, rd, is_load}.
- Reset (async): all valid=0. Consequently fwd_sel=0, stall=0, pipe_busy=0. Reset mid-operation drops every entry immediately.
- Each rising edge:
  - Entry k moves to entry k+1 for k < DEPTH-1. Entry DEPTH-1 retires; the register file write covers it (write-before-read regfile).
  - New entry 0 = {1, issue_rd, issue_load} only when issue_valid && issue_wr && issue_rd != all-ones && !stall && !flush. Otherwise entry 0 becomes a bubble (valid=0).
  - Stall never freezes older entries; they always advance.
- Match rule for port i: entry k matches when valid[k] && rd[k]==src_tag[i] && src_tag[i] != all-ones && src_use[i].
- Priority: the youngest matching entry (lowest k) wins. It sets fwd_sel[i]=k+1. No match gives 0.
- Load hazard: the winning match has is_load && k < LOAD_LAT. Then the port is hazardous and fwd_sel[i] is forced to 0.
- stall = issue_valid && !flush && (any port hazardous). A hazard on an older entry is masked if a younger non-load entry matches the same tag, since that writer supersedes it.
- fwd_sel, stall and pipe_busy are purely combinational from state and current inputs. Latency is zero; there are no registered outputs.
- stall and flush together: flush wins, stall=0, and a bubble enters.
- Repeated stall: the bubble advances the load each cycle. Stall drops automatically once the load reaches stage LOAD_LAT, which takes LOAD_LAT-k cycles.
- The same tag in multiple ports resolves independently and identically per port.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- When defined, adds two outputs:
  - fwd_count (32) counts cycles with issue_valid && !stall && !flush and at least one nonzero fwd_sel.
  - stall_count (32) counts cycles with stall=1.
- Both counters are saturating at 32'hFFFF_FFFF and cleared by reset.
- When undefined, the ports and counters are absent and the core behaviour is identical.

Test Plan (NUM_SRC=3, DEPTH=2, LOAD_LAT=1):
- ALU back-to-back: issue ADD X3 (wr=1, load=0), then a consumer with src_tag[0]=3, src_use=001 -> fwd_sel[0]=1, stall=0. On the following cycle, a reader of X3 gets fwd_sel=2.
- Load-use: issue LDUR X5, then a reader of X5 on port 1 -> stall=1 for exactly one cycle with fwd_sel[1]=0. On the next cycle fwd_sel[1]=2 and stall=0. Entry 0 holds a bubble.
- Priority: ADD X7, then SUB X7, then a reader of X7 on ports 0 and 2 -> both ports get fwd_sel=1 (youngest wins), not 2.
- XZR: issue ADD X31, then a reader with src_tag=31 -> fwd_sel=0, stall=0, pipe_busy=0.
- Flush/reset: assert flush together with a load-use hazard -> stall=0 and no entry inserted. Assert reset asynchronously mid-sequence with 2 valid entries -> pipe_busy falls before the next clk edge.
- Stats (macro on): 3 forwarded issues plus 1 load-use stall -> fwd_count=3, stall_count=1. Preloading near saturation holds at 32'hFFFF_FFFF.
